bbqm_queue_ctrl: RTL and testbench

Parametrised queue controller for the bank-queue display path. It debounces and edge-detects the arrive and depart buttons, and maintains a saturating customer count with empty/full flags and overflow/underflow event pulses. It computes the estimated wait time arithmetically, replacing the fixed lookup table with a sequential divider. Its outputs feed the existing 7-segment decoders: count, plus wait-time tens and ones digits.

---
 rtl/bbqm_queue_ctrl.sv | 147 ++++++++++++++
 tb/tb_bbqm_queue_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bbqm_queue_ctrl.sv
// bbqm_queue_ctrl: debounced arrive/depart queue counter with a sequential-divider
// wait-time estimate and BCD digits for the 7-segment display.
module bbqm_queue_ctrl #(
   parameter int CAPACITY     = 7,
   parameter int MAX_TELLERS  = 3,
   parameter int SERVICE_TIME = 3,
   parameter int TICK_DIV     = 5_000_000,
   localparam int CNT_W = $clog2(CAPACITY + 1),
   localparam int TL_W  = $clog2(MAX_TELLERS + 1),
   localparam int NUM_W = $clog2(SERVICE_TIME * (CAPACITY + MAX_TELLERS - 1) + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_arrive,
   input  logic             btn_depart,
   input  logic [TL_W-1:0]  tellers,
   output logic [CNT_W-1:0] pcount,
   output logic             empty,
   output logic             full,
   output logic             ovf_evt,
   output logic             unf_evt,
   output logic [NUM_W-1:0] wtime,
   output logic [3:0]       wtime_tens,
   output logic [3:0]       wtime_ones,
   output logic             wtime_valid
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(NUM_W + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

   logic [1:0]       arr_s, dep_s;
   logic [TL_W-1:0]  tl_s1, tl_s2, t, lt, ct, rem;
   logic [PW-1:0]    pre;
   logic             tick, arr_smp, dep_smp, arr_evt, dep_evt;
   logic             inc, dec;
   logic [CNT_W-1:0] nxt, lp, cp;
   logic [NUM_W-1:0] num, q;
   logic [TL_W:0]    sh;
   logic             ge, chg_l, chg_c, zero;
   logic [SW-1:0]    step;
   logic [31:0]      wz;
   state_t           st;

   assign tick = pre == PW'(TICK_DIV - 1);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         arr_s   <= '0;
         dep_s   <= '0;
         tl_s1   <= '0;
         tl_s2   <= '0;
         pre     <= '0;
         arr_smp <= 1'b0;
         dep_smp <= 1'b0;
         arr_evt <= 1'b0;
         dep_evt <= 1'b0;
      end else begin
         arr_s   <= {arr_s[0], btn_arrive};
         dep_s   <= {dep_s[0], btn_depart};
         tl_s1   <= tellers;
         tl_s2   <= tl_s1;
         pre     <= tick ? '0 : pre + 1'b1;
         arr_evt <= tick & arr_s[1] & ~arr_smp;
         dep_evt <= tick & dep_s[1] & ~dep_smp;
         if (tick) begin
            arr_smp <= arr_s[1];
            dep_smp <= dep_s[1];
         end
      end

   // simultaneous presses only move the count when the queue is empty
   assign inc = arr_evt & (dep_evt ? empty : ~full);
   assign dec = dep_evt & ~arr_evt & ~empty;
   assign nxt = inc ? pcount + 1'b1 : dec ? pcount - 1'b1 : pcount;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pcount  <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         ovf_evt <= 1'b0;
         unf_evt <= 1'b0;
      end else begin
         pcount  <= nxt;
         empty   <= nxt == '0;
         full    <= nxt == CNT_W'(CAPACITY);
         ovf_evt <= arr_evt & ~dep_evt & full;
         unf_evt <= dep_evt & ~arr_evt & empty;
      end

   assign t     = tl_s2 > TL_W'(MAX_TELLERS) ? TL_W'(MAX_TELLERS) : tl_s2;
   assign chg_l = {pcount, t} != {lp, lt};
   assign chg_c = {pcount, t} != {cp, ct};
   assign zero  = pcount == '0 || t == '0;
   assign num   = NUM_W'(SERVICE_TIME * (int'(pcount) + int'(t) - 1));
   assign sh    = {rem, q[NUM_W-1]};
   assign ge    = sh >= {1'b0, ct};

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st          <= IDLE;
         wtime       <= '0;
         wtime_valid <= 1'b1;
         lp          <= '0;
         lt          <= '0;
         cp          <= '0;
         ct          <= '0;
         q           <= '0;
         rem         <= '0;
         step        <= '0;
      end else begin
         case (st)
            IDLE: if (chg_l) begin
               st          <= LOAD;
               wtime_valid <= 1'b0;
            end
            LOAD: begin
               cp   <= pcount;
               ct   <= t;
               rem  <= '0;
               step <= '0;
               q    <= zero ? '0 : num;
               st   <= zero ? DONE : DIV;
            end
            DIV: if (chg_c) st <= LOAD;
            else begin
               // quotient bits shift in at the bottom as the numerator shifts out the top
               q    <= NUM_W'({q, ge});
               rem  <= ge ? TL_W'(sh - {1'b0, ct}) : TL_W'(sh);
               step <= step + 1'b1;
               if (step == SW'(NUM_W - 1)) st <= DONE;
            end
            default: begin
               wtime       <= q;
               lp          <= cp;
               lt          <= ct;
               wtime_valid <= 1'b1;
               st          <= IDLE;
            end
         endcase
      end

   assign wz         = 32'(wtime);
   assign wtime_tens = 4'(wz / 32'd10);
   assign wtime_ones = 4'(wz % 32'd10);
endmodule

// File: tb/tb_bbqm_queue_ctrl.sv
// tb_bbqm_queue_ctrl: directed scoreboard bench for the queue controller, with a
// second instance at MAX_TELLERS=2 to observe teller clamping.
module tb_bbqm_queue_ctrl;
   localparam int TD = 4;

   logic       clk = 1'b0, reset = 1'b1, ba = 1'b0, bd = 1'b0;
   logic [1:0] tellers = 2'd1;
   logic [2:0] pcount, pc2;
   logic       empty, full, ovf, unf, e2, f2, o2, u2, valid, v2;
   logic [4:0] wtime, w2;
   logic [3:0] tens, ones, tens2, ones2;

   int n_chk = 0, n_fail = 0, ovf_n = 0, unf_n = 0, cyc = 0, exp_p = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   bbqm_queue_ctrl #(.TICK_DIV(TD)) u_dut (
      .clk(clk), .reset(reset), .btn_arrive(ba), .btn_depart(bd), .tellers(tellers),
      .pcount(pcount), .empty(empty), .full(full), .ovf_evt(ovf), .unf_evt(unf),
      .wtime(wtime), .wtime_tens(tens), .wtime_ones(ones), .wtime_valid(valid));

   bbqm_queue_ctrl #(.MAX_TELLERS(2), .TICK_DIV(TD)) u_clamp (
      .clk(clk), .reset(reset), .btn_arrive(ba), .btn_depart(bd), .tellers(tellers),
      .pcount(pc2), .empty(e2), .full(f2), .ovf_evt(o2), .unf_evt(u2),
      .wtime(w2), .wtime_tens(tens2), .wtime_ones(ones2), .wtime_valid(v2));

   always @(negedge clk) begin
      if (ovf) ovf_n += 1;
      if (unf) unf_n += 1;
   end

   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;

   function automatic int exp_w(input int p, input int t, input int mt);
      int te;
      te = t > mt ? mt : t;
      return (p == 0 || te == 0) ? 0 : 3 * (p + te - 1) / te;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int lim);
      for (int i = 0; i < lim && valid !== 1'b1; i++) cyc_n(1);
      chk("wtime_valid rise", valid, 1);
   endtask

   task automatic wait_drop(input int lim);
      for (int i = 0; i < lim && valid !== 1'b0; i++) cyc_n(1);
      chk("wtime_valid drop", valid, 0);
   endtask

   task automatic press(input logic a, input logic d);
      int e;
      e = exp_p;
      if (a && d) e = (exp_p == 0) ? 1 : exp_p;
      else if (a) e = exp_p < 7 ? exp_p + 1 : exp_p;
      else if (d) e = exp_p > 0 ? exp_p - 1 : exp_p;
      exp_p = e;
      exp_q.push_back(e);
      ba = a;
      bd = d;
      cyc_n(2 * TD + 2);
      ba = 1'b0;
      bd = 1'b0;
      cyc_n(3 * TD + 2);
      chk("pcount", int'(pcount), exp_q.pop_front());
      chk("empty", int'(empty), int'(exp_p == 0));
      chk("full", int'(full), int'(exp_p == 7));
      wait_valid(40);
      chk("wtime", int'(wtime), exp_w(exp_p, int'(tellers), 3));
      chk("clamp wtime", int'(w2), exp_w(exp_p, int'(tellers), 2));
   endtask

   initial begin
      int o0, u0, bad;
      cyc_n(3);
      chk("reset pcount", int'(pcount), 0);
      chk("reset empty", int'(empty), 1);
      chk("reset full", int'(full), 0);
      chk("reset ovf", int'(ovf), 0);
      chk("reset unf", int'(unf), 0);
      chk("reset wtime", int'(wtime), 0);
      chk("reset tens", int'(tens), 0);
      chk("reset ones", int'(ones), 0);
      chk("reset valid", int'(valid), 1);
      reset = 1'b0;
      cyc_n(10);

      repeat (7) press(1'b1, 1'b0);
      chk("formula wtime t1", int'(wtime), 21);
      chk("formula tens", int'(tens), 2);
      chk("formula ones", int'(ones), 1);
      tellers = 2'd2;
      wait_drop(10);
      wait_valid(40);
      chk("formula wtime t2", int'(wtime), 12);
      tellers = 2'd3;
      wait_drop(10);
      wait_valid(40);
      chk("formula wtime t3", int'(wtime), 9);
      chk("formula tens t3", int'(tens), 0);
      chk("formula ones t3", int'(ones), 9);

      o0 = ovf_n;
      press(1'b1, 1'b0);
      chk("ovf pulse cycles", ovf_n - o0, 1);
      u0 = unf_n;
      repeat (8) press(1'b0, 1'b1);
      chk("unf pulse cycles", unf_n - u0, 1);

      u0 = unf_n;
      press(1'b1, 1'b1);
      chk("simul at 0 unf", unf_n - u0, 0);
      repeat (6) press(1'b1, 1'b0);
      o0 = ovf_n;
      press(1'b1, 1'b1);
      chk("simul at full ovf", ovf_n - o0, 0);
      repeat (4) press(1'b0, 1'b1);
      o0 = ovf_n;
      u0 = unf_n;
      press(1'b1, 1'b1);
      chk("simul at 3 events", (ovf_n - o0) + (unf_n - u0), 0);

      exp_p = 4;
      exp_q.push_back(exp_p);
      ba = 1'b1;
      cyc_n(20 * TD);
      ba = 1'b0;
      cyc_n(3 * TD + 2);
      chk("held press pcount", int'(pcount), exp_q.pop_front());
      for (int i = 0; i < 2 * TD && cyc % TD != 0; i++) cyc_n(1);
      ba = 1'b1;
      cyc_n(1);
      ba = 1'b0;
      cyc_n(4 * TD);
      chk("glitch pcount", int'(pcount), 4);

      repeat (2) press(1'b1, 1'b0);
      tellers = 2'd1;
      wait_drop(10);
      wait_valid(40);
      chk("pre-restart wtime", int'(wtime), 18);
      tellers = 2'd2;
      cyc_n(4);
      tellers = 2'd3;
      chk("valid low in DIV", int'(valid), 0);
      bad = 0;
      for (int i = 0; i < 60 && valid !== 1'b1; i++) begin
         if (wtime !== 5'd18) bad++;
         cyc_n(1);
      end
      chk("wtime held during restart", bad, 0);
      chk("wtime_valid after restart", int'(valid), 1);
      chk("restart wtime", int'(wtime), 8);
      cyc_n(4);
      chk("clamp valid", int'(v2), 1);
      chk("clamp wtime t3", int'(w2), 10);
      chk("clamp pcount", int'(pc2), 6);

      tellers = 2'd1;
      cyc_n(5);
      chk("valid low before reset", int'(valid), 0);
      reset = 1'b1;
      #1;
      chk("mid-DIV reset pcount", int'(pcount), 0);
      chk("mid-DIV reset empty", int'(empty), 1);
      chk("mid-DIV reset wtime", int'(wtime), 0);
      chk("mid-DIV reset valid", int'(valid), 1);
      cyc_n(1);
      reset = 1'b0;
      cyc_n(1);
      chk("post-reset valid", int'(valid), 1);
      chk("post-reset wtime", int'(wtime), 0);
      exp_p = 0;
      cyc_n(10);

      repeat (2) press(1'b1, 1'b0);
      chk("p2 t1 wtime", int'(wtime), 6);
      tellers = 2'd0;
      wait_drop(10);
      wait_valid(10);
      chk("tellers0 wtime", int'(wtime), 0);
      chk("tellers0 ones", int'(ones), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
